// File: rtl/baud_gen_frac_pkg.sv
// Shared constants for the fractional baud generator: default widths, legal
// oversample range and 16x-oversampled divisors for common rates at 50 MHz.
package baud_gen_frac_pkg;

  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int OVERSAMPLE_MIN = 4;
  localparam int OVERSAMPLE_MAX = 32;

  // 50 MHz / (16 x baud); fraction in 1/16-cycle units
  localparam int DIV_INT_2400    = 1302;
  localparam int DIV_FRAC_2400   = 1;
  localparam int DIV_INT_4800    = 651;
  localparam int DIV_FRAC_4800   = 1;
  localparam int DIV_INT_9600    = 325;
  localparam int DIV_FRAC_9600   = 8;
  localparam int DIV_INT_19200   = 162;
  localparam int DIV_FRAC_19200  = 12;
  localparam int DIV_INT_57600   = 54;
  localparam int DIV_FRAC_57600  = 4;
  localparam int DIV_INT_115200  = 27;
  localparam int DIV_FRAC_115200 = 2;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds div_frac on every os period boundary and
// reports the carry that stretches the following period by one cycle.
module baud_frac_acc
  import baud_gen_frac_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, div_frac};
  assign carry = step & sum[FRAC_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample/bit tick generator with config shadowing and phase
// restart. Define BAUD_CLK_OUT_EN to add the baud_clk square-wave output.
module baud_gen_frac
  import baud_gen_frac_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int DEF_DIV_INT  = DIV_INT_9600,
  parameter int DEF_DIV_FRAC = DIV_FRAC_9600
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              restart,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
`ifdef BAUD_CLK_OUT_EN
  ,
  output logic              baud_clk
`endif
);

  localparam int              PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  logic [DIV_W-1:0]  act_int, pend_int, new_int, use_int, div_m1, cnt;
  logic [FRAC_W-1:0] act_frac, pend_frac, new_frac, use_frac;
  logic [PH_W-1:0]   phase;
  logic              running, load, tick, apply, carry;

  // A same-cycle cfg_load is visible immediately so restart can use it.
  assign new_int  = cfg_load ? cfg_div_int  : pend_int;
  assign new_frac = cfg_load ? cfg_div_frac : pend_frac;

  // The first enabled clock after reset primes the counter like a restart.
  assign load = restart | (enable & ~running);
  assign tick = enable & running & ~restart & (cnt == '0);

  // Pending divisors take over at a period boundary, or at once while frozen.
  assign apply    = load | tick | ~enable;
  assign use_int  = apply ? new_int  : act_int;
  assign use_frac = apply ? new_frac : act_frac;
  assign div_m1   = clamp_div(use_int) - DIV_W'(1);

  baud_frac_acc #(
    .FRAC_W(FRAC_W)
  ) u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (load),
    .step    (tick),
    .div_frac(use_frac),
    .carry   (carry)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      phase     <= '0;
      running   <= 1'b0;
      act_int   <= DIV_W'(DEF_DIV_INT);
      act_frac  <= FRAC_W'(DEF_DIV_FRAC);
      pend_int  <= DIV_W'(DEF_DIV_INT);
      pend_frac <= FRAC_W'(DEF_DIV_FRAC);
    end else begin
      if (cfg_load) begin
        pend_int  <= cfg_div_int;
        pend_frac <= cfg_div_frac;
      end
      act_int  <= use_int;
      act_frac <= use_frac;
      if (load) begin
        cnt     <= div_m1;
        phase   <= '0;
        running <= 1'b1;
      end else if (tick) begin
        cnt   <= div_m1 + {{(DIV_W-1){1'b0}}, carry};
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end else if (enable) begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

  assign os_tick  = tick;
  assign mid_tick = tick & (phase == PH_MID);
  assign bit_tick = tick & (phase == PH_LAST);

`ifdef BAUD_CLK_OUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_clk <= 1'b0;
    end else if (restart) begin
      baud_clk <= 1'b0;
    end else if (tick) begin
      baud_clk <= ~baud_clk;
    end
  end
`endif

endmodule
